// File: rtl/pc_seq_pkg.sv
// Shared types and helpers for the fetch-stage program-counter sequencer.
package pc_seq_pkg;

   typedef enum logic {
      RUN    = 1'b0,
      HALTED = 1'b1
   } pc_state_e;

   typedef enum logic [2:0] {
      SEL_TRAP,
      SEL_BRANCH,
      SEL_RET,
      SEL_CALL,
      SEL_HOLD,
      SEL_INC
   } pc_sel_e;

   // Stack pointer width for a power-of-two depth; never narrower than one bit.
   function automatic int ras_ptr_w(input int depth);
      return (depth <= 2) ? 1 : $clog2(depth);
   endfunction

endpackage

// File: rtl/ret_addr_stack.sv
// Circular return-address stack: a push when full overwrites the oldest entry.
module ret_addr_stack
   import pc_seq_pkg::*;
#(
   parameter int W     = 32,
   parameter int DEPTH = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push_i,
   input  logic         pop_i,
   input  logic [W-1:0] push_data_i,
   output logic [W-1:0] top_data_o,
   output logic         empty_o,
   output logic         full_o,
   output logic         ovf_o,
   output logic         udf_o
);

   localparam int PW = ras_ptr_w(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [PW-1:0] top_q, top_d, top_m1;
   logic [PW:0]   cnt_q, cnt_d;

   assign top_m1     = top_q - PW'(1);
   assign top_data_o = mem_q[top_m1];
   assign empty_o    = (cnt_q == '0);
   assign full_o     = (cnt_q == (PW+1)'(DEPTH));
   assign ovf_o      = push_i & full_o;
   assign udf_o      = pop_i & empty_o;

   // The pointer wraps naturally because DEPTH is a power of two.
   always_comb begin
      top_d = top_q;
      cnt_d = cnt_q;
      if (push_i) begin
         top_d = top_q + PW'(1);
         if (!full_o) cnt_d = cnt_q + (PW+1)'(1);
      end else if (pop_i && !empty_o) begin
         top_d = top_m1;
         cnt_d = cnt_q - (PW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         top_q <= '0;
         cnt_q <= '0;
      end else begin
         top_q <= top_d;
         cnt_q <= cnt_d;
      end
   end

   // Entry contents need no reset; only count and pointer define validity.
   always_ff @(posedge clk) begin
      if (push_i) mem_q[top_q] <= push_data_i;
   end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC sequencer with prioritised redirects and halt/resume.
// The return-address stack is built only when PC_SEQ_RAS_EN is defined.
module pc_sequencer
   import pc_seq_pkg::*;
#(
   parameter int                ADDR_W    = 32,
   parameter int                STRIDE    = 4,
   parameter logic [ADDR_W-1:0] RESET_PC  = '0,
   parameter int                RAS_DEPTH = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              stall,
   input  logic              halt,
   input  logic              resume,
   input  logic              trap,
   input  logic [ADDR_W-1:0] trap_vec,
   input  logic              branch,
   input  logic [ADDR_W-1:0] branch_target,
   input  logic              ret,
   input  logic [ADDR_W-1:0] ret_target,
   input  logic              call,
   input  logic [ADDR_W-1:0] call_target,
   output logic [ADDR_W-1:0] pc,
   output logic              pc_valid,
   output logic              ras_empty,
   output logic              ras_full,
   output logic              ras_ovf,
   output logic              ras_udf
);

   pc_state_e         state_q, state_d;
   pc_sel_e           sel;
   logic [ADDR_W-1:0] pc_q, pc_d, pc_inc, ret_addr;
   logic              stk_empty, stk_full, stk_ovf, stk_udf;
   logic              ovf_q, udf_q;

   assign pc_inc = pc_q + ADDR_W'(STRIDE);

   // Trap is the only redirect honoured while halted.
   always_comb begin
      sel     = SEL_INC;
      state_d = state_q;
      if (trap) begin
         sel     = SEL_TRAP;
         state_d = RUN;
      end else if (state_q == HALTED) begin
         sel = SEL_HOLD;
         if (resume) state_d = RUN;
      end else begin
         if (halt) state_d = HALTED;
         if (branch)      sel = SEL_BRANCH;
         else if (ret)    sel = SEL_RET;
         else if (call)   sel = SEL_CALL;
         else if (stall)  sel = SEL_HOLD;
         else             sel = SEL_INC;
      end
   end

   always_comb begin
      pc_d = pc_q;
      case (sel)
         SEL_TRAP:   pc_d = trap_vec;
         SEL_BRANCH: pc_d = branch_target;
         SEL_RET:    pc_d = ret_addr;
         SEL_CALL:   pc_d = call_target;
         SEL_HOLD:   pc_d = pc_q;
         SEL_INC:    pc_d = pc_inc;
         default:    pc_d = pc_q;
      endcase
   end

`ifdef PC_SEQ_RAS_EN
   logic              push, pop;
   logic [ADDR_W-1:0] ras_top;

   assign push = (sel == SEL_CALL);
   assign pop  = (sel == SEL_RET);

   ret_addr_stack #(
      .W     (ADDR_W),
      .DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk         (clk),
      .rst_n       (rst_n),
      .push_i      (push),
      .pop_i       (pop),
      .push_data_i (pc_inc),
      .top_data_o  (ras_top),
      .empty_o     (stk_empty),
      .full_o      (stk_full),
      .ovf_o       (stk_ovf),
      .udf_o       (stk_udf)
   );

   assign ret_addr = stk_empty ? ret_target : ras_top;
`else
   assign ret_addr  = ret_target;
   assign stk_empty = 1'b1;
   assign stk_full  = 1'b0;
   assign stk_ovf   = 1'b0;
   assign stk_udf   = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= RUN;
         pc_q    <= RESET_PC;
         ovf_q   <= 1'b0;
         udf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ovf_q   <= ovf_q | stk_ovf;
         udf_q   <= stk_udf;
      end
   end

   assign pc        = pc_q;
   assign pc_valid  = (state_q == RUN);
   assign ras_empty = stk_empty;
   assign ras_full  = stk_full;
   assign ras_ovf   = ovf_q;
   assign ras_udf   = udf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed and random checks of pc_sequencer against a queue-based reference model.
module tb_pc_sequencer;

   localparam int          DEPTH  = 4;
   localparam logic [31:0] RST_PC = 32'h100;

   logic        clk = 1'b0;
   logic        rst_n, stall, halt, resume, trap, branch, ret, call;
   logic [31:0] trap_vec, branch_target, ret_target, call_target;

   logic [31:0] pc;
   logic        pc_valid, ras_empty, ras_full, ras_ovf, ras_udf;
   logic [7:0]  pc8;
   logic        pc_valid8, ras_empty8, ras_full8, ras_ovf8, ras_udf8;

   int n_cmp  = 0;
   int n_fail = 0;

   // Reference model state
   logic [31:0] m_pc;
   bit          m_halted, m_ovf, m_udf;
   logic [31:0] m_ras[$];

   always #5 clk = ~clk;

   pc_sequencer #(
      .ADDR_W(32), .STRIDE(4), .RESET_PC(RST_PC), .RAS_DEPTH(DEPTH)
   ) dut (
      .clk(clk), .rst_n(rst_n), .stall(stall), .halt(halt), .resume(resume),
      .trap(trap), .trap_vec(trap_vec), .branch(branch), .branch_target(branch_target),
      .ret(ret), .ret_target(ret_target), .call(call), .call_target(call_target),
      .pc(pc), .pc_valid(pc_valid), .ras_empty(ras_empty), .ras_full(ras_full),
      .ras_ovf(ras_ovf), .ras_udf(ras_udf)
   );

   pc_sequencer #(
      .ADDR_W(8), .STRIDE(4), .RESET_PC(8'hF4), .RAS_DEPTH(DEPTH)
   ) dut8 (
      .clk(clk), .rst_n(rst_n), .stall(stall), .halt(halt), .resume(resume),
      .trap(trap), .trap_vec(trap_vec[7:0]), .branch(branch),
      .branch_target(branch_target[7:0]), .ret(ret), .ret_target(ret_target[7:0]),
      .call(call), .call_target(call_target[7:0]),
      .pc(pc8), .pc_valid(pc_valid8), .ras_empty(ras_empty8), .ras_full(ras_full8),
      .ras_ovf(ras_ovf8), .ras_udf(ras_udf8)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic clear_inputs();
      stall = 0; halt = 0; resume = 0; trap = 0; branch = 0; ret = 0; call = 0;
   endtask

   // Applies the architectural rules to one clock edge with the current inputs.
   task automatic model_edge();
      if (!rst_n) begin
         m_pc = RST_PC; m_halted = 0; m_ovf = 0; m_udf = 0;
         m_ras.delete();
         return;
      end
      m_udf = 0;
      if (trap) begin
         m_pc = trap_vec;
         m_halted = 0;
      end else if (m_halted) begin
         if (resume) m_halted = 0;
      end else begin
         if (halt) m_halted = 1;
         if (branch) m_pc = branch_target;
         else if (ret) begin
`ifdef PC_SEQ_RAS_EN
            if (m_ras.size() > 0) m_pc = m_ras.pop_back();
            else begin
               m_pc = ret_target;
               m_udf = 1;
            end
`else
            m_pc = ret_target;
`endif
         end else if (call) begin
`ifdef PC_SEQ_RAS_EN
            if (m_ras.size() == DEPTH) begin
               m_ovf = 1;
               void'(m_ras.pop_front());
            end
            m_ras.push_back(m_pc + 32'd4);
`endif
            m_pc = call_target;
         end else if (!stall) m_pc = m_pc + 32'd4;
      end
   endtask

   task automatic check_all(input string tag);
      logic exp_empty, exp_full;
`ifdef PC_SEQ_RAS_EN
      exp_empty = (m_ras.size() == 0);
      exp_full  = (m_ras.size() == DEPTH);
`else
      exp_empty = 1'b1;
      exp_full  = 1'b0;
`endif
      chk({tag, ".pc"}, pc, m_pc);
      chk({tag, ".pc_valid"}, {31'd0, pc_valid}, {31'd0, !m_halted});
      chk({tag, ".ras_empty"}, {31'd0, ras_empty}, {31'd0, exp_empty});
      chk({tag, ".ras_full"}, {31'd0, ras_full}, {31'd0, exp_full});
      chk({tag, ".ras_ovf"}, {31'd0, ras_ovf}, {31'd0, m_ovf});
      chk({tag, ".ras_udf"}, {31'd0, ras_udf}, {31'd0, m_udf});
   endtask

   // One clock: model and DUT see the same inputs at the edge; outputs sampled on the falling edge.
   task automatic tick(input string tag);
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_all(tag);
   endtask

   initial begin
      clear_inputs();
      rst_n = 0;
      trap_vec = 32'h800; branch_target = 32'h0; ret_target = 32'h300; call_target = 32'h0;
      @(negedge clk);

      // Reset and free running
      tick("reset0");
      tick("reset1");
      rst_n = 1;
      tick("run1");
      tick("run2");
      chk("w8.at_fc", {24'd0, pc8}, 32'hFC);
      stall = 1;
      tick("stall1");
      tick("stall2");
      stall = 0;
      tick("run3");
      chk("w8.wrap", {24'd0, pc8}, 32'h00);

      // Branch beats stall
      stall = 1; branch = 1; branch_target = 32'h40;
      tick("br_stall");
      chk("w8.br_stall", {24'd0, pc8}, 32'h40);
      clear_inputs();

      // Nested calls then returns past the bottom of the stack
      branch = 1; branch_target = 32'h10; tick("to10"); clear_inputs();
      call = 1; call_target = 32'h80; tick("call1"); clear_inputs();
      branch = 1; branch_target = 32'h20; tick("to20"); clear_inputs();
      call = 1; call_target = 32'h90; tick("call2"); clear_inputs();
      ret = 1; tick("ret1");
      tick("ret2");
      ret_target = 32'h300;
      tick("ret3");
      clear_inputs();
      tick("after_udf");

      // Overflow: five calls into a four-deep stack, then drain
      for (int i = 0; i < 5; i++) begin
         call = 1; call_target = 32'h1000 + 32'(i) * 32'h100;
         tick("ovf_call");
      end
      clear_inputs();
      ret = 1; ret_target = 32'h5A0;
      for (int i = 0; i < 4; i++) tick("ovf_ret");
      clear_inputs();
      tick("ovf_drained");

      // Simultaneous requests
      call = 1; call_target = 32'h2000; tick("push_one"); clear_inputs();
      trap = 1; branch = 1; call = 1; trap_vec = 32'h800; branch_target = 32'h44;
      call_target = 32'h88; tick("trap_br_call"); clear_inputs();
      ret = 1; call = 1; tick("ret_call"); clear_inputs();

      // Halt: the halting cycle still branches, later branches are ignored
      halt = 1; branch = 1; branch_target = 32'h600; tick("halt"); clear_inputs();
      branch = 1; branch_target = 32'h700; tick("halted_br");
      ret = 1; call = 1; tick("halted_rc"); clear_inputs();
      resume = 1; tick("resume"); clear_inputs();
      tick("resumed");

      // Reset while halted with an occupied stack
      call = 1; call_target = 32'h3000; tick("fill1"); tick("fill2"); clear_inputs();
      halt = 1; tick("halt2"); clear_inputs();
      rst_n = 0; tick("mid_reset"); rst_n = 1;
      tick("post_reset");

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         rst_n  = ($urandom_range(0, 99) != 0);
         stall  = ($urandom_range(0, 3) == 0);
         halt   = ($urandom_range(0, 14) == 0);
         resume = ($urandom_range(0, 5) == 0);
         trap   = ($urandom_range(0, 19) == 0);
         branch = ($urandom_range(0, 7) == 0);
         ret    = ($urandom_range(0, 4) == 0);
         call   = ($urandom_range(0, 3) == 0);
         trap_vec      = $urandom;
         branch_target = $urandom;
         ret_target    = $urandom;
         call_target   = $urandom;
         tick("rand");
      end
      clear_inputs();
      rst_n = 1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
